// File: rtl/speed_meter.sv
// speed_meter: reed period measurement, moving average, stall detection
// and divider-based speed calculation for the bike computer.
module speed_meter #(
    parameter int               CNT_W    = 16,
    parameter int               SPD_W    = 12,
    parameter int               CIRC_W   = 8,
    parameter logic [15:0]      CONST    = 16'h49BA,
    parameter int               SPD_MAX  = 99,
    parameter int               AVG_LOG2 = 2,
    parameter logic [CNT_W-1:0] TIMEOUT  = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              reed,
    input  logic [CIRC_W-1:0] circ,
    input  logic              start,
    input  logic              div_busy,
    input  logic              div_ready,
    input  logic [CNT_W-1:0]  div_res,
    output logic [CNT_W-1:0]  div_dividend,
    output logic [CNT_W-1:0]  div_divisor,
    output logic              div_req,
    output logic [SPD_W-1:0]  speed,
    output logic              valid,
    output logic              stalled
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = CNT_W + AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PROD_W = CIRC_W + 16;
    localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(SPD_MAX);
    localparam logic [SPD_W-1:0] SAT_SPD = SPD_W'(SPD_MAX);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FREE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t state, state_nxt;

    logic             reed_q;
    logic             rise;
    logic             primed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ring [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] wptr_nxt;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] avg;
    logic [CNT_W-1:0] dividend;
    logic [PROD_W-1:0] prod;
    logic [SPD_W-1:0] res_sat;

    logic             issue;
    logic             finish;
    logic             fast;
    logic [SPD_W-1:0] fast_spd;
    logic             clr_valid;

    assign rise     = reed & ~reed_q;
    assign avg      = CNT_W'(sum >> AVG_LOG2);
    assign prod     = PROD_W'(circ) * PROD_W'(CONST);
    assign dividend = CNT_W'(prod >> 8);
    assign wptr_nxt = (AVG_LOG2 == 0) ? '0 : wptr + 1'b1;
    assign res_sat  = (div_res > SAT_CNT) ? SAT_SPD : div_res[SPD_W-1:0];

    // Period measurement and moving-average ring
    always_ff @(posedge clk) begin
        if (rst) begin
            reed_q  <= 1'b0;
            cnt     <= '0;
            primed  <= 1'b0;
            stalled <= 1'b1;
            sum     <= '0;
            wptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
        end else begin
            reed_q <= reed;
            if (rise) begin
                cnt <= '0;
                if (!primed) begin
                    primed <= 1'b1;
                end else if (stalled) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        ring[i] <= cnt;
                    end
                    sum     <= SUM_W'(cnt) << AVG_LOG2;
                    stalled <= 1'b0;
                end else begin
                    ring[wptr] <= cnt;
                    sum        <= sum - SUM_W'(ring[wptr]) + SUM_W'(cnt);
                    wptr       <= wptr_nxt;
                end
            end else if (cnt == TIMEOUT) begin
                stalled <= 1'b1;
                primed  <= 1'b0;
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        finish    = 1'b0;
        fast      = 1'b0;
        fast_spd  = '0;
        clr_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr_valid = 1'b1;
                    if (stalled) begin
                        fast = 1'b1;
                    end else if (avg == '0) begin
                        fast     = 1'b1;
                        fast_spd = SAT_SPD;
                    end else begin
                        state_nxt = WAIT_FREE;
                    end
                end
            end
            WAIT_FREE: begin
                if (!div_busy) begin
                    issue     = 1'b1;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (div_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (div_ready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are frozen here so later reed edges cannot disturb a result
    always_ff @(posedge clk) begin
        if (rst) begin
            speed        <= '0;
            valid        <= 1'b0;
            div_req      <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            div_req <= issue;
            if (issue) begin
                div_dividend <= dividend;
                div_divisor  <= avg;
            end
            if (fast) begin
                speed <= fast_spd;
                valid <= 1'b1;
            end else if (finish) begin
                speed <= res_sat;
                valid <= 1'b1;
            end else if (clr_valid) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_speed_meter.sv
// Bench for speed_meter: directed table, random periods against a
// queue-based reference model, and stall/reset corner sequences.
module tb_speed_meter;

    localparam int DEPTH = 4;
    localparam int TMO   = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        reed = 1'b0;
    logic [7:0]  circ = 8'd200;
    logic        start = 1'b0;
    logic        div_busy = 1'b0;
    logic        div_ready = 1'b0;
    logic [15:0] div_res = 16'd0;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_req;
    logic [11:0] speed;
    logic        valid;
    logic        stalled;

    int n_tests = 0;
    int n_fail  = 0;

    int mq[$];
    bit m_primed  = 1'b0;
    bit m_stalled = 1'b1;

    typedef struct {
        int p;
        int n;
        int c;
        int ediv;
        int espd;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    speed_meter #(
        .CNT_W(16), .SPD_W(12), .CIRC_W(8), .CONST(16'h49BA),
        .SPD_MAX(99), .AVG_LOG2(2), .TIMEOUT(16'hFFFF)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .reed(reed), .circ(circ),
        .start(start), .div_busy(div_busy), .div_ready(div_ready),
        .div_res(div_res), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_req(div_req),
        .speed(speed), .valid(valid), .stalled(stalled)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: last DEPTH complete periods kept as a plain queue
    task automatic m_edge(input int p);
        if (!m_primed) begin
            m_primed = 1'b1;
        end else if (m_stalled) begin
            mq.delete();
            repeat (DEPTH) mq.push_back(p);
            m_stalled = 1'b0;
        end else begin
            mq.delete(0);
            mq.push_back(p);
        end
    endtask

    function automatic int m_avg();
        int s;
        s = 0;
        foreach (mq[i]) s += mq[i];
        return s / DEPTH;
    endfunction

    function automatic int m_dvd(input int c);
        return ((c * 18874) / 256) % 65536;
    endfunction

    function automatic int m_speed(input int c);
        int a;
        int q;
        if (m_stalled) return 0;
        a = m_avg();
        if (a == 0) return 99;
        q = m_dvd(c) / a;
        return (q > 99) ? 99 : q;
    endfunction

    task automatic ticks(input int n);
        en = 1'b1;
        repeat (n) step();
        en = 1'b0;
    endtask

    task automatic pulse();
        reed = 1'b1;
        step();
        reed = 1'b0;
        step();
    endtask

    task automatic period(input int p);
        ticks(p);
        pulse();
        m_edge(p);
    endtask

    // Request a speed and play the external divider around it
    task automatic do_req(input string nm, input int imm, input int ediv,
                          input int espd, input int pre, input int blen,
                          input bit dup);
        int  nreq;
        int  res;
        bit  seen;
        nreq = 0;
        seen = 1'b0;
        div_busy = (pre > 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check({nm, " valid_after_start"}, int'(valid), imm);
        if (imm != 0) begin
            check({nm, " fast_speed"}, int'(speed), espd);
            repeat (3) begin
                if (div_req) nreq++;
                step();
            end
            check({nm, " no_div_req"}, nreq, 0);
        end else begin
            repeat (pre) begin
                if (div_req) nreq++;
                step();
            end
            div_busy = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                step();
                if (div_req) seen = 1'b1;
            end
            check({nm, " div_req_seen"}, int'(seen), 1);
            if (seen) begin
                nreq++;
                check({nm, " divisor"}, int'(div_divisor), ediv);
                check({nm, " dividend"}, int'(div_dividend), m_dvd(int'(circ)));
                res = (div_divisor == 0) ? 65535 :
                      int'(div_dividend) / int'(div_divisor);
                div_busy = 1'b1;
                start = dup;
                repeat (blen) begin
                    step();
                    start = 1'b0;
                    if (div_req) nreq++;
                end
                check({nm, " valid_while_busy"}, int'(valid), 0);
                div_busy = 1'b0;
                div_ready = 1'b1;
                div_res = res[15:0];
                step();
                div_ready = 1'b0;
                div_res = 16'd0;
                check({nm, " valid_done"}, int'(valid), 1);
                check({nm, " speed"}, int'(speed), espd);
                repeat (2) begin
                    if (div_req) nreq++;
                    step();
                end
                check({nm, " single_req"}, nreq, 1);
            end
        end
    endtask

    initial begin
        int np;
        int c;
        int a;
        int nreq;
        bit seen;

        tbl[0] = '{1000, 1, 200, 1000, 14};
        tbl[1] = '{2000, 1, 200, 1250, 11};
        tbl[2] = '{2000, 3, 200, 2000, 7};
        tbl[3] = '{100,  4, 200, 100,  99};
        tbl[4] = '{500,  4, 100, 500,  14};
        tbl[5] = '{1000, 2, 200, 750,  19};

        repeat (3) step();
        rst = 1'b0;
        check("rst speed", int'(speed), 0);
        check("rst valid", int'(valid), 0);
        check("rst stalled", int'(stalled), 1);
        check("rst div_req", int'(div_req), 0);
        check("rst dividend", int'(div_dividend), 0);
        check("rst divisor", int'(div_divisor), 0);

        pulse();
        m_edge(0);
        check("prime keeps stalled", int'(stalled), 1);

        foreach (tbl[i]) begin
            circ = 8'(tbl[i].c);
            repeat (tbl[i].n) period(tbl[i].p);
            check($sformatf("tbl%0d stalled", i), int'(stalled), int'(m_stalled));
            do_req($sformatf("tbl%0d", i), 0, tbl[i].ediv, tbl[i].espd,
                   i % 2, 2, 1'b0);
        end

        for (int k = 0; k < 12; k++) begin
            np = $urandom_range(3, 1);
            c = $urandom_range(255, 1);
            circ = 8'(c);
            repeat (np) period($urandom_range(120, 0));
            a = m_avg();
            do_req($sformatf("rnd%0d", k), (a == 0) ? 1 : 0, a, m_speed(c),
                   $urandom_range(3, 0), $urandom_range(4, 1), 1'b0);
        end

        circ = 8'd200;
        ticks(300);
        reed = 1'b1;
        repeat (50) step();
        reed = 1'b0;
        step();
        m_edge(300);
        ticks(400);
        pulse();
        m_edge(400);
        do_req("held_high", 0, m_avg(), m_speed(200), 2, 3, 1'b1);

        ticks(TMO);
        check("stall boundary", int'(stalled), 0);
        step();
        check("stall set", int'(stalled), 1);
        m_stalled = 1'b1;
        m_primed = 1'b0;
        do_req("stalled_req", 1, 0, m_speed(200), 0, 1, 1'b0);
        pulse();
        m_edge(0);
        check("stall first edge", int'(stalled), 1);
        period(300);
        check("stall second edge", int'(stalled), 0);

        repeat (4) period(0);
        do_req("zero_avg", 1, 0, m_speed(200), 0, 1, 1'b0);

        period(500);
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (div_req) seen = 1'b1;
        end
        check("abort div_req_seen", int'(seen), 1);
        div_busy = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        div_busy = 1'b0;
        div_ready = 1'b1;
        div_res = 16'd5;
        step();
        div_ready = 1'b0;
        div_res = 16'd0;
        check("abort speed", int'(speed), 0);
        check("abort valid", int'(valid), 0);
        check("abort stalled", int'(stalled), 1);
        check("abort div_req", int'(div_req), 0);
        check("abort divisor", int'(div_divisor), 0);
        check("abort dividend", int'(div_dividend), 0);
        nreq = 0;
        repeat (3) begin
            step();
            if (div_req || valid) nreq++;
        end
        check("abort quiet", nreq, 0);
        mq.delete();
        m_primed = 1'b0;
        m_stalled = 1'b1;
        do_req("post_rst", 1, 0, m_speed(200), 0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
